// File: rtl/tiny8_fetch.sv
// tiny8_fetch: program counter and single-word instruction fetch feeding the tiny8 IR.
// Optional TINY8_FETCH_TIMEOUT_EN adds a bounded memory wait with a sticky fetch_err.
module tiny8_fetch #(
   parameter int                 ADDR_W         = 8,
   parameter logic [ADDR_W-1:0]  RESET_PC       = '0,
   parameter int                 TIMEOUT_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fetch_start,
   input  logic              pc_redirect,
   input  logic [ADDR_W-1:0] redirect_target,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_read,
   input  logic [7:0]        mem_rdata,
   input  logic              mem_resp,
   output logic              ir_load,
   output logic [7:0]        ir_word,
   output logic              fetch_done,
   output logic              squashed,
   output logic [ADDR_W-1:0] pc,
`ifdef TINY8_FETCH_TIMEOUT_EN
   output logic              fetch_err,
`endif
   output logic              busy
);
   typedef enum logic [1:0] {IDLE, REQ, DELIVER} state_t;
   state_t state, state_n;
   logic [ADDR_W-1:0] pc_n, held, held_n;
   logic [7:0] ir_n;
   logic squash_pend, pend_n, sq_n;
`ifdef TINY8_FETCH_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt, cnt_n;
   logic err_n;
`endif
   assign mem_read   = state == REQ;
   assign mem_addr   = pc;
   assign ir_load    = state == DELIVER;
   assign fetch_done = state == DELIVER;
   assign busy       = state != IDLE;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         ir_word     <= '0;
         held        <= RESET_PC;
         squash_pend <= 1'b0;
         squashed    <= 1'b0;
`ifdef TINY8_FETCH_TIMEOUT_EN
         cnt         <= '0;
         fetch_err   <= 1'b0;
`endif
      end else begin
         state       <= state_n;
         pc          <= pc_n;
         ir_word     <= ir_n;
         held        <= held_n;
         squash_pend <= pend_n;
         squashed    <= sq_n;
`ifdef TINY8_FETCH_TIMEOUT_EN
         cnt         <= cnt_n;
         fetch_err   <= err_n;
`endif
      end
   end
   always_comb begin
      state_n = state;
      pc_n    = pc;
      ir_n    = ir_word;
      held_n  = held;
      pend_n  = squash_pend;
      sq_n    = 1'b0;
`ifdef TINY8_FETCH_TIMEOUT_EN
      cnt_n   = '0;
      err_n   = fetch_err;
`endif
      unique case (state)
         IDLE: begin
            if (pc_redirect) pc_n = redirect_target;
            else if (fetch_start) state_n = REQ;
         end
         REQ: begin
            if (mem_resp) begin
               // A redirect seen at any point of the request discards the returned word
               if (squash_pend || pc_redirect) begin
                  sq_n    = 1'b1;
                  pc_n    = pc_redirect ? redirect_target : held;
                  pend_n  = 1'b0;
                  state_n = IDLE;
               end else begin
                  ir_n    = mem_rdata;
                  state_n = DELIVER;
               end
            end else begin
               if (pc_redirect) begin
                  pend_n = 1'b1;
                  held_n = redirect_target;
               end
`ifdef TINY8_FETCH_TIMEOUT_EN
               if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  state_n = IDLE;
                  pend_n  = 1'b0;
                  err_n   = 1'b1;
               end else cnt_n = cnt + 1'b1;
`endif
            end
         end
         DELIVER: begin
            pc_n    = pc_redirect ? redirect_target : pc + 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_tiny8_fetch.sv
// tb_tiny8_fetch: directed checks of fetch timing, PC wrap, redirect squash and reset abandon.
// Timeout checks run only when TINY8_FETCH_TIMEOUT_EN is defined.
module tb_tiny8_fetch;
   logic clk = 1'b0;
   logic rst_n, fetch_start, pc_redirect, mem_resp;
   logic [7:0] redirect_target, mem_rdata;
   logic [7:0] mem_addr, ir_word, pc;
   logic mem_read, ir_load, fetch_done, squashed, busy;
`ifdef TINY8_FETCH_TIMEOUT_EN
   logic fetch_err;
`endif
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   tiny8_fetch #(.ADDR_W(8), .RESET_PC(8'h00), .TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .fetch_start(fetch_start), .pc_redirect(pc_redirect),
      .redirect_target(redirect_target), .mem_addr(mem_addr), .mem_read(mem_read),
      .mem_rdata(mem_rdata), .mem_resp(mem_resp), .ir_load(ir_load), .ir_word(ir_word),
      .fetch_done(fetch_done), .squashed(squashed), .pc(pc),
`ifdef TINY8_FETCH_TIMEOUT_EN
      .fetch_err(fetch_err),
`endif
      .busy(busy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; fetch_start = 1'b0; pc_redirect = 1'b0; mem_resp = 1'b0;
      redirect_target = 8'h00; mem_rdata = 8'h00;
      step(); step();
      chk("rst_pc", pc, 8'h00);
      chk("rst_busy", busy, 0);
      chk("rst_read", mem_read, 0);
      chk("rst_ir", ir_word, 8'h00);
      chk("rst_load", ir_load, 0);
      chk("rst_sq", squashed, 0);
      rst_n = 1'b1;
      // basic fetch with immediate response
      fetch_start = 1'b1; step(); fetch_start = 1'b0;
      chk("t1_read", mem_read, 1);
      chk("t1_addr", mem_addr, 8'h00);
      chk("t1_busy", busy, 1);
      chk("t1_noload", ir_load, 0);
      mem_resp = 1'b1; mem_rdata = 8'hA7; step(); mem_resp = 1'b0;
      chk("t1_load", ir_load, 1);
      chk("t1_done", fetch_done, 1);
      chk("t1_word", ir_word, 8'hA7);
      chk("t1_read_off", mem_read, 0);
      step();
      chk("t1_pc", pc, 8'h01);
      chk("t1_load_off", ir_load, 0);
      chk("t1_idle", busy, 0);
      // redirect to 0xFF, fetch with three-cycle wait, PC wraps
      pc_redirect = 1'b1; redirect_target = 8'hFF; step(); pc_redirect = 1'b0;
      chk("t2_pc", pc, 8'hFF);
      chk("t2_noread", mem_read, 0);
      fetch_start = 1'b1; step(); fetch_start = 1'b0;
      chk("t2_w1", mem_read, 1);
      chk("t2_a1", mem_addr, 8'hFF);
      step();
      chk("t2_w2", mem_read, 1);
      step();
      chk("t2_w3", mem_read, 1);
      chk("t2_a3", mem_addr, 8'hFF);
      chk("t2_noload", ir_load, 0);
      mem_resp = 1'b1; mem_rdata = 8'h3C; step(); mem_resp = 1'b0;
      chk("t2_load", ir_load, 1);
      chk("t2_word", ir_word, 8'h3C);
      step();
      chk("t2_wrap", pc, 8'h00);
      chk("t2_hold", ir_word, 8'h3C);
      // redirect during REQ squashes the later response
      fetch_start = 1'b1; step(); fetch_start = 1'b0;
      pc_redirect = 1'b1; redirect_target = 8'h40; step(); pc_redirect = 1'b0;
      chk("t3_still_req", mem_read, 1);
      chk("t3_addr", mem_addr, 8'h00);
      chk("t3_nosq", squashed, 0);
      mem_resp = 1'b1; mem_rdata = 8'h55; step(); mem_resp = 1'b0;
      chk("t3_sq", squashed, 1);
      chk("t3_noload", ir_load, 0);
      chk("t3_nodone", fetch_done, 0);
      chk("t3_pc", pc, 8'h40);
      chk("t3_busy", busy, 0);
      chk("t3_word", ir_word, 8'h3C);
      step();
      chk("t3_sq_off", squashed, 0);
      // redirect coincident with the response also squashes
      fetch_start = 1'b1; step(); fetch_start = 1'b0;
      pc_redirect = 1'b1; redirect_target = 8'h22; mem_resp = 1'b1; mem_rdata = 8'h66;
      step(); pc_redirect = 1'b0; mem_resp = 1'b0;
      chk("t3b_sq", squashed, 1);
      chk("t3b_pc", pc, 8'h22);
      chk("t3b_noload", ir_load, 0);
      chk("t3b_word", ir_word, 8'h3C);
      // redirect beats simultaneous fetch_start in IDLE
      fetch_start = 1'b1; pc_redirect = 1'b1; redirect_target = 8'h10; step();
      fetch_start = 1'b0; pc_redirect = 1'b0;
      chk("t4_pc", pc, 8'h10);
      chk("t4_noread", mem_read, 0);
      chk("t4_busy", busy, 0);
      fetch_start = 1'b1; step(); fetch_start = 1'b0;
      chk("t4_read", mem_read, 1);
      chk("t4_addr", mem_addr, 8'h10);
      mem_resp = 1'b1; mem_rdata = 8'h11; step(); mem_resp = 1'b0;
      chk("t4_load", ir_load, 1);
      // redirect during DELIVER overrides the increment
      pc_redirect = 1'b1; redirect_target = 8'h80; step(); pc_redirect = 1'b0;
      chk("t4_deliver_redir", pc, 8'h80);
      chk("t4_word", ir_word, 8'h11);
      // reset mid-request abandons it; later response ignored
      fetch_start = 1'b1; step(); fetch_start = 1'b0;
      chk("t5_read", mem_read, 1);
      rst_n = 1'b0; step(); rst_n = 1'b1;
      chk("t5_pc", pc, 8'h00);
      chk("t5_read_off", mem_read, 0);
      chk("t5_ir", ir_word, 8'h00);
      mem_resp = 1'b1; mem_rdata = 8'h77; step(); mem_resp = 1'b0;
      chk("t5_noload", ir_load, 0);
      chk("t5_ir2", ir_word, 8'h00);
      chk("t5_busy", busy, 0);
`ifdef TINY8_FETCH_TIMEOUT_EN
      chk("t6_err0", fetch_err, 0);
      fetch_start = 1'b1; step(); fetch_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("t6_wait", mem_read, 1);
         step();
      end
      chk("t6_drop", mem_read, 0);
      chk("t6_err", fetch_err, 1);
      chk("t6_pc", pc, 8'h00);
      chk("t6_noload", ir_load, 0);
      mem_resp = 1'b1; mem_rdata = 8'h5A; step(); mem_resp = 1'b0;
      chk("t6_late", ir_load, 0);
      chk("t6_sticky", fetch_err, 1);
      fetch_start = 1'b1; step(); fetch_start = 1'b0;
      chk("t6_retry", mem_addr, 8'h00);
      chk("t6_retry_rd", mem_read, 1);
      mem_resp = 1'b1; mem_rdata = 8'h99; step(); mem_resp = 1'b0;
      chk("t6_load", ir_load, 1);
      chk("t6_word", ir_word, 8'h99);
      step();
      chk("t6_pc2", pc, 8'h01);
      chk("t6_sticky2", fetch_err, 1);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
